// File: rtl/kv_cache_pkg.sv
// Shared types and address-split width helpers for the kv_cache load cache.
package kv_cache_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LOOKUP     = 3'd1,
      FETCH_REQ  = 3'd2,
      FETCH_WAIT = 3'd3,
      RESP       = 3'd4
   } state_e;

   function automatic int offset_w(input int line_size);
      return $clog2(line_size);
   endfunction

   function automatic int index_w(input int line_num);
      return $clog2(line_num);
   endfunction

   function automatic int tag_w(input int addr_width, input int line_size, input int line_num);
      return addr_width - offset_w(line_size) - index_w(line_num);
   endfunction

   localparam int DEF_OFFSET_W = offset_w(4);
   localparam int DEF_INDEX_W  = index_w(64);
   localparam int DEF_TAG_W    = tag_w(32, 4, 64);

endpackage

// File: rtl/kv_cache_way.sv
// One cache way: per-set valid bit, tag and line, combinational lookup, whole-line fill.
module kv_cache_way #(
   parameter int LINE_W   = 128,
   parameter int TAG_W    = 24,
   parameter int IDX_W    = 6,
   parameter int LINE_NUM = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [IDX_W-1:0]  index_i,
   input  logic [TAG_W-1:0]  tag_i,
   output logic              valid_o,
   output logic              hit_o,
   output logic [LINE_W-1:0] line_o,
   input  logic              wr_en_i,
   input  logic [LINE_W-1:0] wr_line_i
);

   logic [LINE_NUM-1:0] valid_q;
   logic [TAG_W-1:0]    tag_q  [LINE_NUM];
   logic [LINE_W-1:0]   data_q [LINE_NUM];

   assign valid_o = valid_q[index_i];
   assign hit_o   = valid_q[index_i] && (tag_q[index_i] == tag_i);
   assign line_o  = data_q[index_i];

   // Valid bits: cleared by reset, set by a fill.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[index_i] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; the valid bit guards them.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         tag_q[index_i]  <= tag_i;
         data_q[index_i] <= wr_line_i;
      end
   end

endmodule

// File: rtl/kv_cache.sv
// Blocking read-only set-associative load cache with single outstanding load and whole-line refill.
module kv_cache
   import kv_cache_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int WAY_NUM    = 2,
   parameter int LINE_SIZE  = 4,
   parameter int LINE_NUM   = 64
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   output logic [DATA_WIDTH-1:0]           o_load_data,
   output logic                            o_load_valid,
   input  logic                            i_load_ready,
   input  logic [ADDR_WIDTH-1:0]           i_load_addr,
   input  logic                            i_load_valid,
   output logic                            o_load_ready,
   input  logic [DATA_WIDTH-1:0]           i_store_data,
   input  logic [ADDR_WIDTH-1:0]           i_store_addr,
   input  logic                            i_store_valid,
   output logic                            o_store_ready,
   input  logic [DATA_WIDTH-1:0]           i_fetch_data [LINE_SIZE-1:0],
   input  logic                            i_fetch_valid,
   output logic                            o_fetch_ready,
   output logic [ADDR_WIDTH-1:0]           o_fetch_addr,
   output logic                            o_fetch_valid,
   input  logic                            i_fetch_ready,
   input  logic                            i_line_valid,
   input  logic [LINE_SIZE*DATA_WIDTH-1:0] i_line_data,
   output logic                            o_line_ready,
   output logic [ADDR_WIDTH-1:0]           o_line_addr,
   output logic [LINE_SIZE*DATA_WIDTH-1:0] o_line_data
);

   localparam int OFF_W  = offset_w(LINE_SIZE);
   localparam int IDX_W  = index_w(LINE_NUM);
   localparam int TAG_W  = tag_w(ADDR_WIDTH, LINE_SIZE, LINE_NUM);
   localparam int WAY_W  = $clog2(WAY_NUM);
   localparam int LINE_W = LINE_SIZE * DATA_WIDTH;

   state_e                 state_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [ADDR_WIDTH-1:0]  fetch_addr_q;
   logic [DATA_WIDTH-1:0]  load_data_q;
   logic                   load_valid_q;
   logic                   load_ready_q;
   logic                   fetch_valid_q;
   logic                   fetch_ready_q;
   logic [WAY_W-1:0]       ptr_q [LINE_NUM];

   logic [OFF_W-1:0]       off_s;
   logic [IDX_W-1:0]       idx_s;
   logic [TAG_W-1:0]       tag_s;
   logic [WAY_NUM-1:0]     way_valid_s;
   logic [WAY_NUM-1:0]     way_hit_s;
   logic [WAY_NUM-1:0]     way_wr_s;
   logic [LINE_W-1:0]      way_line_s [WAY_NUM];
   logic [LINE_W-1:0]      fill_line_s;
   logic [DATA_WIDTH-1:0]  hit_word_s;
   logic [WAY_W-1:0]       victim_s;
   logic                   hit_s;
   logic                   fill_s;
   logic                   any_inv_s;
   logic                   unused_ok_s;

   assign off_s = addr_q[OFF_W-1:0];
   assign idx_s = addr_q[OFF_W +: IDX_W];
   assign tag_s = addr_q[ADDR_WIDTH-1 -: TAG_W];

   for (genvar w = 0; w < WAY_NUM; w++) begin : g_way
      kv_cache_way #(
         .LINE_W   (LINE_W),
         .TAG_W    (TAG_W),
         .IDX_W    (IDX_W),
         .LINE_NUM (LINE_NUM)
      ) u_way (
         .clk_i     (i_clk),
         .rst_i     (i_rst),
         .index_i   (idx_s),
         .tag_i     (tag_s),
         .valid_o   (way_valid_s[w]),
         .hit_o     (way_hit_s[w]),
         .line_o    (way_line_s[w]),
         .wr_en_i   (way_wr_s[w]),
         .wr_line_i (fill_line_s)
      );
   end

   assign hit_s     = |way_hit_s;
   assign any_inv_s = ~&way_valid_s;
   assign fill_s    = (state_q == FETCH_WAIT) && fetch_ready_q && i_fetch_valid;

   // Pack the refill line, word i at bit slice i.
   always_comb begin
      fill_line_s = '0;
      for (int i = 0; i < LINE_SIZE; i++) begin
         fill_line_s[i*DATA_WIDTH +: DATA_WIDTH] = i_fetch_data[i];
      end
   end

   // Word select from whichever way hits (at most one can).
   always_comb begin
      hit_word_s = '0;
      for (int w = 0; w < WAY_NUM; w++) begin
         hit_word_s = hit_word_s |
            (way_hit_s[w] ? way_line_s[w][int'(off_s)*DATA_WIDTH +: DATA_WIDTH] : '0);
      end
   end

   // Victim: lowest invalid way wins (descending scan), else the round-robin pointer.
   always_comb begin
      victim_s = ptr_q[idx_s];
      for (int w = WAY_NUM - 1; w >= 0; w--) begin
         victim_s = way_valid_s[w] ? victim_s : WAY_W'(w);
      end
      for (int w = 0; w < WAY_NUM; w++) begin
         way_wr_s[w] = fill_s && (victim_s == WAY_W'(w));
      end
   end

   // Replacement pointer advances only when it actually picked the victim.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < LINE_NUM; i++) begin
            ptr_q[i] <= '0;
         end
      end else if (fill_s && !any_inv_s) begin
         ptr_q[idx_s] <= ptr_q[idx_s] + 1'b1;
      end
   end

   // Control FSM; every handshake output is a register set on the transition into its state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         fetch_addr_q  <= '0;
         load_data_q   <= '0;
         load_valid_q  <= 1'b0;
         load_ready_q  <= 1'b0;
         fetch_valid_q <= 1'b0;
         fetch_ready_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (load_ready_q && i_load_valid) begin
                  addr_q       <= i_load_addr;
                  load_ready_q <= 1'b0;
                  state_q      <= LOOKUP;
               end else begin
                  load_ready_q <= 1'b1;
               end
            end
            LOOKUP: begin
               if (hit_s) begin
                  load_data_q  <= hit_word_s;
                  load_valid_q <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  fetch_addr_q  <= {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                  fetch_valid_q <= 1'b1;
                  state_q       <= FETCH_REQ;
               end
            end
            FETCH_REQ: begin
               if (i_fetch_ready) begin
                  fetch_valid_q <= 1'b0;
                  fetch_ready_q <= 1'b1;
                  state_q       <= FETCH_WAIT;
               end
            end
            FETCH_WAIT: begin
               if (i_fetch_valid) begin
                  fetch_ready_q <= 1'b0;
                  load_data_q   <= i_fetch_data[off_s];
                  load_valid_q  <= 1'b1;
                  state_q       <= RESP;
               end
            end
            RESP: begin
               if (i_load_ready) begin
                  load_valid_q <= 1'b0;
                  load_ready_q <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: begin
               load_valid_q  <= 1'b0;
               load_ready_q  <= 1'b0;
               fetch_valid_q <= 1'b0;
               fetch_ready_q <= 1'b0;
               state_q       <= IDLE;
            end
         endcase
      end
   end

   assign o_load_data   = load_data_q;
   assign o_load_valid  = load_valid_q;
   assign o_load_ready  = load_ready_q;
   assign o_fetch_addr  = fetch_addr_q;
   assign o_fetch_valid = fetch_valid_q;
   assign o_fetch_ready = fetch_ready_q;

   assign o_store_ready = 1'b0;
   assign o_line_ready  = 1'b0;
   assign o_line_addr   = '0;
   assign o_line_data   = '0;

   assign unused_ok_s = ^{i_store_data, i_store_addr, i_store_valid, i_line_valid, i_line_data};

endmodule

// File: tb/tb_kv_cache.sv
// Directed self-checking bench for kv_cache with a fixed-latency line memory model.
module tb_kv_cache;

   logic         clk = 1'b0;
   logic         i_rst;
   logic [31:0]  o_load_data;
   logic         o_load_valid;
   logic         i_load_ready;
   logic [31:0]  i_load_addr;
   logic         i_load_valid;
   logic         o_load_ready;
   logic [31:0]  i_store_data;
   logic [31:0]  i_store_addr;
   logic         i_store_valid;
   logic         o_store_ready;
   logic [31:0]  i_fetch_data [3:0];
   logic         i_fetch_valid;
   logic         o_fetch_ready;
   logic [31:0]  o_fetch_addr;
   logic         o_fetch_valid;
   logic         i_fetch_ready;
   logic         i_line_valid;
   logic [127:0] i_line_data;
   logic         o_line_ready;
   logic [31:0]  o_line_addr;
   logic [127:0] o_line_data;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          fetch_cnt = 0;
   logic [31:0] last_fetch_addr = 32'h0;
   bit          mem_hold = 1'b0;
   bit          mem_seen = 1'b0;
   int          mem_cnt  = 0;
   logic [31:0] mem_line = 32'h0;

   always #5 clk = ~clk;

   kv_cache dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .o_load_data   (o_load_data),
      .o_load_valid  (o_load_valid),
      .i_load_ready  (i_load_ready),
      .i_load_addr   (i_load_addr),
      .i_load_valid  (i_load_valid),
      .o_load_ready  (o_load_ready),
      .i_store_data  (i_store_data),
      .i_store_addr  (i_store_addr),
      .i_store_valid (i_store_valid),
      .o_store_ready (o_store_ready),
      .i_fetch_data  (i_fetch_data),
      .i_fetch_valid (i_fetch_valid),
      .o_fetch_ready (o_fetch_ready),
      .o_fetch_addr  (o_fetch_addr),
      .o_fetch_valid (o_fetch_valid),
      .i_fetch_ready (i_fetch_ready),
      .i_line_valid  (i_line_valid),
      .i_line_data   (i_line_data),
      .o_line_ready  (o_line_ready),
      .o_line_addr   (o_line_addr),
      .o_line_data   (o_line_data)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] line, input int i);
      return line + 32'(i);
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Count accepted fetch requests and remember the address of the last one.
   always @(posedge clk) begin
      if (o_fetch_valid === 1'b1 && i_fetch_ready === 1'b1) begin
         fetch_cnt       <= fetch_cnt + 1;
         last_fetch_addr <= o_fetch_addr;
      end
   end

   // Memory: raise ready one cycle after seeing a request, return the line 3 cycles after acceptance.
   initial begin
      i_fetch_ready = 1'b0;
      i_fetch_valid = 1'b0;
      for (int i = 0; i < 4; i++) i_fetch_data[i] = 32'h0;
      forever begin
         @(negedge clk);
         i_fetch_valid = 1'b0;
         if (i_fetch_ready) begin
            i_fetch_ready = 1'b0;
            mem_cnt = 3;
         end else if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
               i_fetch_valid = 1'b1;
               for (int i = 0; i < 4; i++) i_fetch_data[i] = mem_word(mem_line, i);
            end
         end else if (o_fetch_valid === 1'b1 && !mem_hold) begin
            if (mem_seen) begin
               i_fetch_ready = 1'b1;
               mem_line = o_fetch_addr;
               mem_seen = 1'b0;
            end else begin
               mem_seen = 1'b1;
            end
         end else begin
            mem_seen = 1'b0;
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_load_data"},   o_load_data,   128'h0);
      chk({tag, "_load_valid"},  o_load_valid,  128'h0);
      chk({tag, "_load_ready"},  o_load_ready,  128'h0);
      chk({tag, "_fetch_valid"}, o_fetch_valid, 128'h0);
      chk({tag, "_fetch_addr"},  o_fetch_addr,  128'h0);
      chk({tag, "_fetch_ready"}, o_fetch_ready, 128'h0);
      chk({tag, "_store_ready"}, o_store_ready, 128'h0);
      chk({tag, "_line_ready"},  o_line_ready,  128'h0);
      chk({tag, "_line_addr"},   o_line_addr,   128'h0);
      chk({tag, "_line_data"},   o_line_data,   128'h0);
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clk);
      i_rst = 1'b1;
      @(posedge clk);
      @(negedge clk); #1;
      chk_zero(tag);
      @(negedge clk);
      i_rst = 1'b0;
      @(negedge clk); #1;
      chk({tag, "_ready_after"}, o_load_ready, 128'h1);
   endtask

   task automatic issue(input string tag, input logic [31:0] addr);
      bit acc = 1'b0;
      @(negedge clk); #1;
      i_load_addr  = addr;
      i_load_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         if (o_load_ready === 1'b1) begin
            acc = 1'b1;
            break;
         end
         @(negedge clk); #1;
      end
      if (acc) @(posedge clk);
      chk({tag, "_accept"}, acc, 128'h1);
      @(negedge clk); #1;
      i_load_valid = 1'b0;
      i_load_addr  = 32'hDEAD_BEEF;
      chk({tag, "_ready_fall"}, o_load_ready, 128'h0);
   endtask

   task automatic do_load(input string tag, input logic [31:0] addr, input int exp_fetch,
                          input int resp_hold, input bit fetch_hold);
      int          f0 = fetch_cnt;
      int          cyc = 0;
      int          refill_cyc = -1;
      bit          got = 1'b0;
      bit          fh = fetch_hold;
      logic [31:0] line = {addr[31:2], 2'b00};
      logic [31:0] exp = mem_word(line, int'(addr[1:0]));
      i_load_ready = (resp_hold == 0);
      mem_hold = fetch_hold;
      issue(tag, addr);
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk); #1;
         if (o_load_valid === 1'b1) begin
            got = 1'b1;
            cyc = k;
            break;
         end
         if (fh && o_fetch_valid === 1'b1) begin
            for (int h = 0; h < 5; h++) begin
               chk({tag, "_fvalid_hold"}, o_fetch_valid, 128'h1);
               chk({tag, "_faddr_hold"},  o_fetch_addr,  line);
               @(negedge clk); #1;
            end
            mem_hold = 1'b0;
            fh = 1'b0;
         end
         if (i_fetch_valid && o_fetch_ready === 1'b1) refill_cyc = k;
      end
      chk({tag, "_resp_seen"}, got, 128'h1);
      chk({tag, "_data"}, o_load_data, exp);
      chk({tag, "_fetches"}, fetch_cnt - f0, exp_fetch);
      if (exp_fetch != 0) chk({tag, "_fetch_addr"}, last_fetch_addr, line);
      if (exp_fetch == 0) chk({tag, "_hit_edge"}, cyc + 1, 128'd2);
      if (refill_cyc >= 0) chk({tag, "_refill_lat"}, cyc - refill_cyc, 128'd1);
      for (int h = 0; h < resp_hold; h++) begin
         @(negedge clk); #1;
         chk({tag, "_hold_valid"}, o_load_valid, 128'h1);
         chk({tag, "_hold_data"},  o_load_data,  exp);
         chk({tag, "_hold_ready"}, o_load_ready, 128'h0);
      end
      i_load_ready = 1'b1;
      @(posedge clk);
      @(negedge clk); #1;
      chk({tag, "_ready_back"}, o_load_ready, 128'h1);
      chk({tag, "_valid_drop"}, o_load_valid, 128'h0);
      mem_hold = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit reached = 1'b0;
      i_rst = 1'b0;
      i_load_ready = 1'b1;
      i_load_addr = 32'h0;
      i_load_valid = 1'b0;
      i_store_data = 32'h0;
      i_store_addr = 32'h0;
      i_store_valid = 1'b0;
      i_line_valid = 1'b0;
      i_line_data = 128'h0;

      apply_reset("por");
      do_load("s1_miss",  32'h1111_1001, 1, 0, 1'b0);
      chk("s1_fetch_line", last_fetch_addr, 128'h1111_1000);
      do_load("s2_hit",   32'h1111_1001, 0, 0, 1'b0);
      do_load("s3_idx1",  32'h1111_1004, 1, 0, 1'b0);
      do_load("s3_hit",   32'h1111_1002, 0, 0, 1'b0);

      // Set 0 replacement: ways fill 0,1; pointer then evicts way 0, then way 1, then way 0.
      apply_reset("r2");
      do_load("s4_a",      32'h2222_2000, 1, 0, 1'b0);
      do_load("s4_b",      32'h3333_3000, 1, 0, 1'b0);
      do_load("s4_c",      32'h4444_4000, 1, 0, 1'b0);
      do_load("s4_b_hit",  32'h3333_3000, 0, 0, 1'b0);
      do_load("s4_c_hit",  32'h4444_4000, 0, 0, 1'b0);
      do_load("s4_a_miss", 32'h2222_2000, 1, 0, 1'b0);
      do_load("s4_c_hit2", 32'h4444_4000, 0, 0, 1'b0);
      do_load("s4_b_miss", 32'h3333_3000, 1, 0, 1'b0);
      do_load("s4_a_hit",  32'h2222_2000, 0, 0, 1'b0);

      do_load("s5_resp_hold",  32'h2222_2003, 0, 5, 1'b0);
      do_load("s5_fetch_hold", 32'h5555_5002, 1, 0, 1'b1);

      // Reset while waiting for the refill; the late line must be dropped.
      i_load_ready = 1'b1;
      issue("s6_issue", 32'h7777_7005);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk); #1;
         if (o_fetch_ready === 1'b1) begin
            reached = 1'b1;
            break;
         end
      end
      chk("s6_fetch_wait", reached, 128'h1);
      apply_reset("s6_rst");
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); #1;
         chk("s6_no_resp",  o_load_valid,  128'h0);
         chk("s6_no_fetch", o_fetch_valid, 128'h0);
      end

      i_store_valid = 1'b1;
      i_store_data  = 32'hFFFF_FFFF;
      i_store_addr  = 32'h3333_3001;
      i_line_valid  = 1'b1;
      i_line_data   = {4{32'hA5A5_A5A5}};
      do_load("s6_remiss", 32'h3333_3001, 1, 0, 1'b0);
      do_load("s6_rehit",  32'h3333_3003, 0, 0, 1'b0);
      chk("s6_store_ready", o_store_ready, 128'h0);
      chk("s6_line_ready",  o_line_ready,  128'h0);
      chk("s6_line_addr",   o_line_addr,   128'h0);
      chk("s6_line_data",   o_line_data,   128'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
